// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM states and access owner.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    EXT_RD = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  // Read-return state for the port that owns an issued read.
  function automatic state_t rd_state(input owner_t own);
    return (own == OWN_EXT) ? EXT_RD : CPU_RD;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_starve_counter.sv
// Saturating count of back-to-back CPU issues while the external port waits.
module starve_counter #(
  parameter int MAX = 4,
  localparam int CW = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment, increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == MAX_V);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter (CPU / external loader) in front of a single synchronous-read
// data memory. CPU has priority unless the external port has been starved.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [31:0]       ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t              state_q, state_d;
  logic [31:0]         cpu_hold_q, cpu_hold_d;
  logic [31:0]         ext_hold_q, ext_hold_d;
  owner_t              owner;
  logic                issue;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [31:0]         win_wdata;
  logic                sat;
  logic                cnt_inc;
  logic                cnt_clr;
  logic                cpu_wr_issue;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^{cpu_addr[31:ADDR_W], ext_addr[31:ADDR_W]};

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .sat (sat)
  );

  // Arbitration, combinational issue, and read-return muxing.
  always_comb begin
    state_d    = state_q;
    cpu_hold_d = cpu_hold_q;
    ext_hold_d = ext_hold_q;
    owner      = OWN_CPU;
    issue      = 1'b0;
    win_we     = 1'b0;
    win_addr   = '0;
    win_wdata  = 32'd0;
    cpu_rvalid = 1'b0;
    ext_rvalid = 1'b0;
    cpu_rdata  = cpu_hold_q;
    ext_rdata  = ext_hold_q;
    if (!rst) begin
      // Outputs are forced quiet while reset is asserted.
      state_d   = IDLE;
      cpu_rdata = 32'd0;
      ext_rdata = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req || ext_req) begin
            issue     = 1'b1;
            owner     = (ext_req && (!cpu_req || sat)) ? OWN_EXT : OWN_CPU;
            win_we    = (owner == OWN_EXT) ? ext_we : cpu_we;
            win_addr  = (owner == OWN_EXT) ? ext_addr[ADDR_W-1:0] : cpu_addr[ADDR_W-1:0];
            win_wdata = (owner == OWN_EXT) ? ext_wdata : cpu_wdata;
            if (win_we) begin
              state_d = IDLE;
            end else begin
              state_d = rd_state(owner);
            end
          end else begin
            state_d = IDLE;
          end
        end
        CPU_RD: begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = mem_rdata;
          cpu_hold_d = mem_rdata;
          state_d    = IDLE;
        end
        EXT_RD: begin
          ext_rvalid = 1'b1;
          ext_rdata  = mem_rdata;
          ext_hold_d = mem_rdata;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign mem_en       = issue;
  assign mem_we       = issue & win_we;
  assign mem_addr     = win_addr;
  assign mem_wdata    = win_wdata;
  assign ext_gnt      = issue & (owner == OWN_EXT);
  assign cpu_wr_issue = issue & (owner == OWN_CPU) & win_we;
  assign cpu_stall    = cpu_req & ~cpu_wr_issue & ~cpu_rvalid;
  assign cnt_inc      = issue & (owner == OWN_CPU) & ext_req;
  assign cnt_clr      = ext_gnt | ~ext_req;

  // State and read-hold registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cpu_hold_q <= 32'd0;
      ext_hold_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cpu_hold_q <= cpu_hold_d;
      ext_hold_q <= ext_hold_d;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the word-address width driven to data memory.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive CPU grants allowed while ext_req is pending.
REQ-003 The block SHALL have the following ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 resets on the clock edge.
- cpu_req  in  1  CPU memory-stage access request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  32  word address; only bits [ADDR_W-1:0] are used.
- cpu_wdata  in  32  write data.
- cpu_stall  out  1  pipeline freeze request.
- cpu_rvalid  out  1  read data valid pulse.
- cpu_rdata  out  32  read data.
- ext_req, ext_we, ext_addr[32], ext_wdata[32]  in  same meaning as the cpu_* inputs, for the external loader/DMA port.
- ext_gnt  out  1  accept pulse.
- ext_rvalid  out  1  read data valid pulse.
- ext_rdata  out  32  read data.
- mem_en, mem_we  out  1  memory enable and write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  synchronous-read memory output, valid the cycle after issue.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, CPU_RD, EXT_RD.
REQ-005 In IDLE with at least one request, one winner SHALL be selected and issued combinationally in that cycle: mem_en=1, and mem_we/mem_addr/mem_wdata taken from the winner.
REQ-006 Priority SHALL go to the CPU, except that the external port SHALL win when ext_req=1 and starve_cnt==STARVE_MAX.
REQ-007 A write issue SHALL complete in the same cycle: ext_gnt=1 for an external winner, cpu_stall=0 for a CPU winner; the FSM SHALL stay in IDLE.
REQ-008 A read issue SHALL pulse ext_gnt (external winner only) and transition to CPU_RD or EXT_RD.
REQ-009 In CPU_RD or EXT_RD, the block SHALL:
- drive mem_en=0;
- assert the matching rvalid for exactly one cycle;
- drive the matching rdata = mem_rdata;
- capture that value into the port's hold register;
- return to IDLE.
No new issue SHALL occur in this cycle, so read throughput is 1 per 2 cycles.
REQ-010 Outside its rvalid cycle, each rdata output SHALL present its hold register; hold registers SHALL reset to 0.
REQ-011 cpu_stall SHALL be cpu_req AND NOT (CPU write issued this cycle) AND NOT (cpu_rvalid this cycle).
REQ-012 starve_cnt (width clog2(STARVE_MAX+1)) SHALL:
- increment on each CPU issue while ext_req=1, saturating at STARVE_MAX;
- clear on an external issue, or in any cycle with ext_req=0.
REQ-013 Requesters SHALL hold req/we/addr/wdata stable until the write completes or rvalid occurs; the block SHALL NOT latch request fields.
REQ-014 With no request in IDLE, the block SHALL drive mem_en=0 and mem_we=0; mem_addr and mem_wdata SHALL be 0.
REQ-015 mem_we SHALL never be 1 while mem_en=0.
REQ-016 On simultaneous requests with starve_cnt<STARVE_MAX, the CPU SHALL win; the external port SHALL keep ext_gnt=0 and wait.

Reset
REQ-017 On rst=0 at a clock edge, the block SHALL reset state to IDLE, starve_cnt to 0, and both hold registers to 0.
REQ-018 During and after reset, all outputs SHALL be 0 except cpu_stall, which follows REQ-011.
REQ-019 A reset in CPU_RD/EXT_RD SHALL abort the read: no rvalid pulse, and the requester must re-request.

Structure
REQ-020 Package data_mem_arbiter_pkg SHALL hold the state enum (IDLE, CPU_RD, EXT_RD) and a 1-bit owner type (OWN_CPU, OWN_EXT).
REQ-021 The saturating counter SHALL be a sub-module, starve_counter, with parameter MAX and ports inc, clr, sat.
REQ-022 Output muxing SHALL be combinational from state and winner; no extra pipeline stage.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- CPU write: cpu_req=1, we=1, addr=0x5, wdata=0xDEADBEEF -> same cycle mem_en=1, mem_we=1, mem_addr=0x5, cpu_stall=0; a later read of 0x5 returns 0xDEADBEEF with cpu_rvalid 1 cycle after issue.
- CPU read stall: cpu_req=1, we=0 -> cpu_stall=1 in the issue cycle, 0 in the CPU_RD cycle with cpu_rvalid=1; cpu_rdata holds the value after cpu_req drops.
- Contention: cpu_req and ext_req both held for writes -> CPU issues for 4 consecutive cycles, the 5th cycle issues ext with ext_gnt=1, starve_cnt returns to 0.
- Mixed reads: ext read of 0x3 (contents 0x12345678) -> ext_gnt pulse, ext_rvalid next cycle with 0x12345678; cpu_rvalid stays 0 throughout.
- Reset mid-read: rst=0 during CPU_RD -> no cpu_rvalid, all outputs 0, state IDLE on the next cycle.
- Idle: no requests for 10 cycles -> mem_en=0, mem_we=0 throughout.
